// File: rtl/spi_prog_loader_if.sv
// rtl/spi_prog_loader_if.sv - command/run handshakes and processor control pins of the program loader
interface spi_prog_loader_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_target;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       run_valid;
  logic       run_ready;
  logic       proc_done;
  logic [1:0] mode;
  logic       mosi;
  logic       run_done;
  logic       run_timeout;
  logic       busy;

  modport master (
    output cmd_valid, cmd_target, cmd_addr, cmd_data, run_valid, proc_done,
    input  cmd_ready, run_ready, mode, mosi, run_done, run_timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_addr, cmd_data, run_valid, proc_done,
    output cmd_ready, run_ready, mode, mosi, run_done, run_timeout, busy
  );
endinterface

// File: rtl/spi_prog_loader.sv
// rtl/spi_prog_loader.sv - serial loader for processor instruction/data memories plus run control
module spi_prog_loader #(
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned RUN_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  spi_prog_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, RUN_ENTER, RUN_WAIT, RUN_EXIT} state_e;

  state_e      state_q, state_d;
  logic [11:0] frame_q, frame_d;
  logic        target_q, target_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic        timeout_q, timeout_d;
  logic [1:0]  mode_q, mode_d;
  logic        mosi_q, mosi_d;
  logic        run_done_q, run_done_d;

  // One counter serves as bit index in SHIFT, gap length in GAP and run timer in RUN_*.
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          frame_d  = {bus.cmd_data, bus.cmd_addr};
          target_d = bus.cmd_target;
          cnt_d    = 16'd0;
          state_d  = SHIFT;
        end else if (bus.run_valid) begin
          timeout_d = 1'b0;
          cnt_d     = 16'd0;
          state_d   = RUN_ENTER;
        end
      end
      SHIFT: begin
        cnt_d = cnt_inc;
        if (cnt_q == 16'd11) begin
          cnt_d   = 16'd0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_inc;
        if (cnt_q == 16'(GAP_CYCLES - 1)) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
        end
      end
      RUN_ENTER, RUN_WAIT: begin
        cnt_d = cnt_inc;
        if (cnt_inc == 16'(RUN_TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = RUN_EXIT;
        end else if (state_q == RUN_ENTER && !bus.proc_done) begin
          state_d = RUN_WAIT;
        end else if (state_q == RUN_WAIT && bus.proc_done) begin
          state_d = RUN_EXIT;
        end
      end
      RUN_EXIT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (rst) begin
      state_d   = IDLE;
      frame_d   = 12'd0;
      target_d  = 1'b0;
      cnt_d     = 16'd0;
      timeout_d = 1'b0;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    case (state_d)
      SHIFT:               mode_d = target_d ? 2'b10 : 2'b01;
      RUN_ENTER, RUN_WAIT: mode_d = 2'b11;
      default:             mode_d = 2'b00;
    endcase
    mosi_d     = (state_d == SHIFT) ? frame_d[cnt_d[3:0]] : 1'b0;
    run_done_d = (state_d == RUN_EXIT);
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    frame_q    <= frame_d;
    target_q   <= target_d;
    cnt_q      <= cnt_d;
    timeout_q  <= timeout_d;
    mode_q     <= mode_d;
    mosi_q     <= mosi_d;
    run_done_q <= run_done_d;
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.run_ready   = (state_q == IDLE) && !bus.cmd_valid;
  assign bus.busy        = (state_q != IDLE);
  assign bus.mode        = mode_q;
  assign bus.mosi        = mosi_q;
  assign bus.run_done    = run_done_q;
  assign bus.run_timeout = timeout_q;

endmodule

// File: tb/tb_spi_prog_loader.sv
// tb/tb_spi_prog_loader.sv - directed self-checking bench for spi_prog_loader
module tb_spi_prog_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_prog_loader_if bus();
  spi_prog_loader_if bus_to();

  spi_prog_loader u_dut (.clk(clk), .rst(rst), .bus(bus));
  spi_prog_loader #(.GAP_CYCLES(2), .RUN_TIMEOUT(8)) u_to (.clk(clk), .rst(rst), .bus(bus_to));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // processor model and pin monitors on the default instance
  logic [7:0]  icache [16];
  logic [7:0]  dcache [16];
  logic [11:0] sh = 12'd0;
  logic        tgt = 1'b0;
  logic [1:0]  prev_mode = 2'b00;
  int nbits = 0, wr_count = 0, rd_pulses = 0, bad_trans = 0, bad_mosi = 0;
  int starts [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.mode == 2'b01 || bus.mode == 2'b10) begin
      if (nbits < 12) sh[nbits] = bus.mosi;
      nbits++;
      tgt = bus.mode[1];
    end else begin
      if (nbits == 12) begin
        if (tgt) dcache[sh[3:0]] = sh[11:4];
        else     icache[sh[3:0]] = sh[11:4];
        wr_count++;
      end
      nbits = 0;
    end
    if (bus.mode != 2'b00 && prev_mode == 2'b00) starts.push_back(cyc);
    if (bus.mode != 2'b00 && prev_mode != 2'b00 && bus.mode != prev_mode) bad_trans++;
    if (bus.mosi === 1'b1 && bus.mode != 2'b01 && bus.mode != 2'b10) bad_mosi++;
    if (bus.run_done === 1'b1) rd_pulses++;
    prev_mode = bus.mode;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic t, input logic [3:0] a, input logic [7:0] d, output bit ok);
    logic rdy;
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = t;
    bus.cmd_addr   = a;
    bus.cmd_data   = d;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rdy = bus.cmd_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_target = 0; bus.cmd_addr = 0; bus.cmd_data = 0;
    bus.run_valid = 0; bus.proc_done = 1;
    bus_to.cmd_valid = 0; bus_to.cmd_target = 0; bus_to.cmd_addr = 0; bus_to.cmd_data = 0;
    bus_to.run_valid = 0; bus_to.proc_done = 1;
    step(); step(); step();
    @(negedge clk);
    n_checks++; if (bus.mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode got %b want 00", bus.mode); end
    n_checks++; if (bus.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got %b want 0", bus.mosi); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.run_done !== 1'b0) begin n_fail++; $display("FAIL reset_run_done got %b want 0", bus.run_done); end
    n_checks++; if (bus.run_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_run_timeout got %b want 0", bus.run_timeout); end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    n_checks++; if (bus.run_ready !== 1'b1) begin n_fail++; $display("FAIL reset_run_ready got %b want 1", bus.run_ready); end
  endtask

  task automatic test_data_write();
    bit ok;
    logic [11:0] exp_f;
    exp_f = 12'hA35;
    step();
    send_cmd(1'b1, 4'h5, 8'hA3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL data_accept got %0d want 1", ok); end
    bus.cmd_valid = 0; bus.cmd_target = 0; bus.cmd_addr = 4'hF; bus.cmd_data = 8'hFF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mode !== 2'b10 || bus.mosi !== exp_f[k]) begin
        n_fail++;
        $display("FAIL data_shift bit %0d got mode %b mosi %b want mode 10 mosi %b", k, bus.mode, bus.mosi, exp_f[k]);
      end
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mode !== 2'b00 || bus.mosi !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL data_gap %0d got mode %b mosi %b busy %b want 00 0 1", g, bus.mode, bus.mosi, bus.busy);
      end
    end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL data_idle_busy got %b want 0", bus.busy); end
    n_checks++; if (dcache[5] !== 8'hA3) begin n_fail++; $display("FAIL data_dcache5 got %h want a3", dcache[5]); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int n0;
    step();
    n0 = starts.size();
    send_cmd(1'b0, 4'h0, 8'h11, ok1);
    send_cmd(1'b0, 4'h1, 8'h22, ok2);
    bus.cmd_valid = 0;
    n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_accept got %0d%0d want 11", ok1, ok2); end
    repeat (16) step();
    n_checks++;
    if (starts.size() < n0 + 2) begin
      n_fail++; $display("FAIL b2b_frames got %0d want 2", starts.size() - n0);
    end else if (starts[n0+1] - starts[n0] != 15) begin
      n_fail++; $display("FAIL b2b_spacing got %0d want 15", starts[n0+1] - starts[n0]);
    end
    n_checks++; if (icache[0] !== 8'h11) begin n_fail++; $display("FAIL b2b_icache0 got %h want 11", icache[0]); end
    n_checks++; if (icache[1] !== 8'h22) begin n_fail++; $display("FAIL b2b_icache1 got %h want 22", icache[1]); end
  endtask

  task automatic test_priority();
    int n01, zeros;
    bit seen11, got;
    n01 = 0; zeros = 0; seen11 = 0; got = 0;
    step();
    bus.cmd_valid = 1; bus.cmd_target = 0; bus.cmd_addr = 4'h2; bus.cmd_data = 8'h5C;
    bus.run_valid = 1; bus.proc_done = 1;
    @(negedge clk);
    n_checks++; if (bus.run_ready !== 1'b0) begin n_fail++; $display("FAIL prio_run_ready got %b want 0", bus.run_ready); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL prio_cmd_ready got %b want 1", bus.cmd_ready); end
    step();
    bus.cmd_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mode == 2'b01) n01++;
      else if (bus.mode == 2'b00 && n01 > 0) zeros++;
      else if (bus.mode == 2'b11) begin seen11 = 1; break; end
    end
    n_checks++; if (!seen11) begin n_fail++; $display("FAIL prio_run_start got %0d want 1", seen11); end
    n_checks++; if (n01 != 12) begin n_fail++; $display("FAIL prio_frame_len got %0d want 12", n01); end
    n_checks++; if (zeros != 3) begin n_fail++; $display("FAIL prio_idle_sep got %0d want 3", zeros); end
    step();
    bus.run_valid = 0; bus.proc_done = 0;
    step();
    bus.proc_done = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.run_done === 1'b1) begin got = 1; break; end
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL prio_run_done got %0d want 1", got); end
    n_checks++; if (icache[2] !== 8'h5C) begin n_fail++; $display("FAIL prio_icache2 got %h want 5c", icache[2]); end
  endtask

  task automatic test_normal_run();
    int rd0, bad;
    bit found;
    bad = 0; found = 0;
    step();
    rd0 = rd_pulses;
    bus.run_valid = 1; bus.proc_done = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mode == 2'b11) begin found = 1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL run_start got %0d want 1", found); end
    step();
    bus.run_valid = 0; bus.proc_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mode !== 2'b11) bad++;
      step();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL run_hold got %0d non-11 cycles want 0", bad); end
    bus.proc_done = 1;
    @(negedge clk);
    n_checks++; if (bus.mode !== 2'b11) begin n_fail++; $display("FAIL run_last got %b want 11", bus.mode); end
    @(negedge clk);
    n_checks++; if (bus.mode !== 2'b00) begin n_fail++; $display("FAIL run_exit_mode got %b want 00", bus.mode); end
    n_checks++; if (bus.run_done !== 1'b1) begin n_fail++; $display("FAIL run_done_pulse got %b want 1", bus.run_done); end
    n_checks++; if (bus.run_timeout !== 1'b0) begin n_fail++; $display("FAIL run_no_timeout got %b want 0", bus.run_timeout); end
    @(negedge clk);
    n_checks++; if (bus.run_done !== 1'b0) begin n_fail++; $display("FAIL run_done_width got %b want 0", bus.run_done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL run_idle_busy got %b want 0", bus.busy); end
    n_checks++; if (rd_pulses - rd0 != 1) begin n_fail++; $display("FAIL run_done_count got %0d want 1", rd_pulses - rd0); end
  endtask

  task automatic test_timeout();
    int n11;
    bit found, got;
    found = 0; got = 0; n11 = 0;
    step();
    bus_to.proc_done = 0; bus_to.run_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_to.mode == 2'b11) begin found = 1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL to_start got %0d want 1", found); end
    n11 = 1;
    step();
    bus_to.run_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_to.mode == 2'b11) n11++;
      else break;
    end
    n_checks++; if (n11 != 8) begin n_fail++; $display("FAIL to_run_cycles got %0d want 8", n11); end
    n_checks++; if (bus_to.mode !== 2'b00) begin n_fail++; $display("FAIL to_exit_mode got %b want 00", bus_to.mode); end
    n_checks++; if (bus_to.run_done !== 1'b1) begin n_fail++; $display("FAIL to_run_done got %b want 1", bus_to.run_done); end
    n_checks++; if (bus_to.run_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag got %b want 1", bus_to.run_timeout); end
    @(negedge clk);
    n_checks++; if (bus_to.run_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b want 1", bus_to.run_timeout); end
    step();
    bus_to.run_valid = 1;
    found = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_to.mode == 2'b11) begin found = 1; break; end
    end
    n_checks++; if (!found || bus_to.run_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear got start %0d flag %b want 1 0", found, bus_to.run_timeout); end
    step();
    bus_to.run_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_to.run_done === 1'b1) begin got = 1; break; end
    end
    n_checks++; if (!got || bus_to.run_timeout !== 1'b1) begin n_fail++; $display("FAIL to_second got done %0d flag %b want 1 1", got, bus_to.run_timeout); end
  endtask

  task automatic test_reset_mid_frame();
    int wc0;
    bit ok;
    step();
    wc0 = wr_count;
    send_cmd(1'b0, 4'h7, 8'h99, ok);
    bus.cmd_valid = 0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmf_accept got %0d want 1", ok); end
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mode !== 2'b00) begin n_fail++; $display("FAIL rmf_mode got %b want 00", bus.mode); end
    n_checks++; if (bus.mosi !== 1'b0) begin n_fail++; $display("FAIL rmf_mosi got %b want 0", bus.mosi); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_cmd_ready got %b want 1", bus.cmd_ready); end
    repeat (3) step();
    n_checks++; if (wr_count != wc0) begin n_fail++; $display("FAIL rmf_no_write got %0d writes want 0", wr_count - wc0); end
    n_checks++; if (icache[7] !== 8'h00) begin n_fail++; $display("FAIL rmf_icache7 got %h want 00", icache[7]); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      icache[i] = 8'h00;
      dcache[i] = 8'h00;
    end
    test_reset();
    test_data_write();
    test_back_to_back();
    test_priority();
    test_normal_run();
    test_timeout();
    test_reset_mid_frame();
    n_checks++; if (bad_trans != 0) begin n_fail++; $display("FAIL mode_direct_change got %0d want 0", bad_trans); end
    n_checks++; if (bad_mosi != 0) begin n_fail++; $display("FAIL mosi_outside_shift got %0d want 0", bad_mosi); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
